in_decode: RTL

Instruction-decode stage of the 5-stage RISC-V pipeline, directly downstream of the fetch stage's IF/ID register. It consumes the fetched instruction and PC, reads the 32x32 register file, generates the immediate and control signals, and detects load-use hazards. The resulting stall request goes back to fetch, and the decoded fields are captured into the ID/EX pipeline register.

---
 rtl/in_decode.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/in_decode.sv
// in_decode: RISC-V instruction-decode stage.
// Combinational decode, register read, immediate generation and load-use
// stall detection, followed by the ID/EX pipeline register. The stage also
// owns the 32x32 register file that write-back updates.
// Optional feature: define ID_WB_BYPASS_EN to forward the write-back value
// to the read ports in the same cycle (write-through register file).
module in_decode (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction_in,
  input  logic [31:0] PC_in,
  input  logic        PCSrc,
  input  logic        RegWrite_in,
  input  logic [4:0]  rd_in,
  input  logic [31:0] WriteData,
  output logic        PCWrite,
  output logic [31:0] PC_out,
  output logic [31:0] ReadData1_out,
  output logic [31:0] ReadData2_out,
  output logic [31:0] Immediate_out,
  output logic [4:0]  rs1_out,
  output logic [4:0]  rs2_out,
  output logic [4:0]  rd_out,
  output logic [2:0]  funct3_out,
  output logic [6:0]  funct7_out,
  output logic        Branch_out,
  output logic        Jump_out,
  output logic        MemRead_out,
  output logic        MemWrite_out,
  output logic        MemtoReg_out,
  output logic        ALUSrc_out,
  output logic        RegWrite_out,
  output logic [1:0]  ALUOp_out
);

  typedef enum logic [6:0] {
    OP_R      = 7'b0110011,
    OP_I_ALU  = 7'b0010011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_LUI    = 7'b0110111
  } opcode_e;

  logic [31:0] regs [32];

  opcode_e     opcode;
  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  funct3;
  logic [6:0]  funct7;

  logic        dec_branch, dec_jump, dec_memread, dec_memwrite;
  logic        dec_memtoreg, dec_alusrc, dec_regwrite;
  logic [1:0]  dec_aluop;
  logic [31:0] dec_imm;
  logic        use_rs1, use_rs2;
  logic [31:0] rdata1, rdata2;

  assign opcode = opcode_e'(instruction_in[6:0]);
  assign rd     = instruction_in[11:7];
  assign funct3 = instruction_in[14:12];
  assign rs1    = instruction_in[19:15];
  assign rs2    = instruction_in[24:20];
  assign funct7 = instruction_in[31:25];

  // Opcode decode: control signals, immediate format and source-register usage
  always_comb begin
    dec_branch   = 1'b0;
    dec_jump     = 1'b0;
    dec_memread  = 1'b0;
    dec_memwrite = 1'b0;
    dec_memtoreg = 1'b0;
    dec_alusrc   = 1'b0;
    dec_regwrite = 1'b0;
    dec_aluop    = 2'b00;
    dec_imm      = '0;
    use_rs1      = 1'b0;
    use_rs2      = 1'b0;
    case (opcode)
      OP_R: begin
        dec_regwrite = 1'b1;
        dec_aluop    = 2'b10;
        use_rs1      = 1'b1;
        use_rs2      = 1'b1;
      end
      OP_I_ALU: begin
        dec_alusrc   = 1'b1;
        dec_regwrite = 1'b1;
        dec_aluop    = 2'b11;
        dec_imm      = {{20{instruction_in[31]}}, instruction_in[31:20]};
        use_rs1      = 1'b1;
      end
      OP_LOAD: begin
        dec_memread  = 1'b1;
        dec_memtoreg = 1'b1;
        dec_alusrc   = 1'b1;
        dec_regwrite = 1'b1;
        dec_imm      = {{20{instruction_in[31]}}, instruction_in[31:20]};
        use_rs1      = 1'b1;
      end
      OP_STORE: begin
        dec_memwrite = 1'b1;
        dec_alusrc   = 1'b1;
        dec_imm      = {{20{instruction_in[31]}}, instruction_in[31:25],
                        instruction_in[11:7]};
        use_rs1      = 1'b1;
        use_rs2      = 1'b1;
      end
      OP_BRANCH: begin
        dec_branch   = 1'b1;
        dec_aluop    = 2'b01;
        dec_imm      = {{19{instruction_in[31]}}, instruction_in[31],
                        instruction_in[7], instruction_in[30:25],
                        instruction_in[11:8], 1'b0};
        use_rs1      = 1'b1;
        use_rs2      = 1'b1;
      end
      OP_JAL: begin
        dec_jump     = 1'b1;
        dec_regwrite = 1'b1;
        dec_alusrc   = 1'b1;
        dec_imm      = {{11{instruction_in[31]}}, instruction_in[31],
                        instruction_in[19:12], instruction_in[20],
                        instruction_in[30:21], 1'b0};
      end
      OP_JALR: begin
        dec_jump     = 1'b1;
        dec_regwrite = 1'b1;
        dec_alusrc   = 1'b1;
        dec_imm      = {{20{instruction_in[31]}}, instruction_in[31:20]};
        use_rs1      = 1'b1;
      end
      OP_LUI: begin
        dec_alusrc   = 1'b1;
        dec_regwrite = 1'b1;
        dec_imm      = {instruction_in[31:12], 12'h000};
      end
      default: ;
    endcase
  end

  // Register read; x0 is hard-wired to zero
  always_comb begin
    rdata1 = (rs1 == 5'd0) ? '0 : regs[rs1];
    rdata2 = (rs2 == 5'd0) ? '0 : regs[rs2];
`ifdef ID_WB_BYPASS_EN
    if (RegWrite_in && (rd_in != 5'd0) && (rd_in == rs1)) rdata1 = WriteData;
    if (RegWrite_in && (rd_in != 5'd0) && (rd_in == rs2)) rdata2 = WriteData;
`endif
  end

  // Load-use hazard: the load in EX targets a register this instruction reads
  always_comb begin
    PCWrite = MemRead_out && (rd_out != 5'd0) &&
              ((use_rs1 && (rs1 == rd_out)) || (use_rs2 && (rs2 == rd_out)));
  end

  // Register file write port; writes proceed regardless of stall or flush
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
    end else if (RegWrite_in && (rd_in != 5'd0)) begin
      regs[rd_in] <= WriteData;
    end
  end

  // ID/EX register: reset, then flush, then stall bubble, else capture
  always_ff @(posedge clk) begin
    if (reset || PCSrc || PCWrite) begin
      PC_out        <= '0;
      ReadData1_out <= '0;
      ReadData2_out <= '0;
      Immediate_out <= '0;
      rs1_out       <= '0;
      rs2_out       <= '0;
      rd_out        <= '0;
      funct3_out    <= '0;
      funct7_out    <= '0;
      Branch_out    <= 1'b0;
      Jump_out      <= 1'b0;
      MemRead_out   <= 1'b0;
      MemWrite_out  <= 1'b0;
      MemtoReg_out  <= 1'b0;
      ALUSrc_out    <= 1'b0;
      RegWrite_out  <= 1'b0;
      ALUOp_out     <= '0;
    end else begin
      PC_out        <= PC_in;
      ReadData1_out <= rdata1;
      ReadData2_out <= rdata2;
      Immediate_out <= dec_imm;
      rs1_out       <= rs1;
      rs2_out       <= rs2;
      rd_out        <= rd;
      funct3_out    <= funct3;
      funct7_out    <= funct7;
      Branch_out    <= dec_branch;
      Jump_out      <= dec_jump;
      MemRead_out   <= dec_memread;
      MemWrite_out  <= dec_memwrite;
      MemtoReg_out  <= dec_memtoreg;
      ALUSrc_out    <= dec_alusrc;
      RegWrite_out  <= dec_regwrite;
      ALUOp_out     <= dec_aluop;
    end
  end

endmodule
